// File: rtl/uart_rx_drain_ctrl.sv
// Drains an FWFT UART RX FIFO into a valid/ready byte stream in bursts started by a level threshold or a character timeout.
// Receiver error pulses accumulate into sticky write-one-to-clear status that drives a maskable interrupt.
module uart_rx_drain_ctrl #(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout_cycles,
    input  logic                     i_flush,
    input  logic                     i_rx_byte,
    input  logic                     i_threshold,
    input  logic                     i_fifo_empty,
    input  logic [7:0]               i_fifo_rd_data,
    output logic                     o_fifo_rd_en,
    output logic                     o_fifo_clear,
    input  logic                     i_parity_error,
    input  logic                     i_frame_error,
    input  logic                     i_overflow_error,
    output logic [7:0]               o_tdata,
    output logic                     o_tvalid,
    output logic                     o_tlast,
    input  logic                     i_tready,
    input  logic [3:0]               i_status_clr,
    input  logic [3:0]               i_irq_en,
    output logic [3:0]               o_status,
    output logic                     o_irq,
    output logic [1:0]               o_state
);

    // Stream handshake: a byte transfers on a rising edge where o_tvalid and i_tready are
    // both high; once raised, o_tvalid and its o_tdata/o_tlast stay put until that edge (or a flush).
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POP   = 2'd1,
        S_CHECK = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]               tdata_q, tdata_d;
    logic                     tlast_q, tlast_d;
    logic                     tvalid_q, tvalid_d;
    logic                     clear_q, clear_d;
    logic [3:0]               status_q, status_d;
    logic                     irq_q, irq_d;
    logic                     timeout_hit;
    logic                     trigger;
    logic                     timeout_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            clear_q  <= 1'b0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            clear_q  <= clear_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign timeout_hit = (cnt_q >= i_timeout_cycles) && (i_timeout_cycles != '0);
    assign trigger     = i_enable && !i_fifo_empty && (i_threshold || timeout_hit);

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        tdata_d     = tdata_q;
        tlast_d     = tlast_q;
        tvalid_d    = tvalid_q;
        clear_d     = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The counter only runs while a partial, un-thresholded FIFO sits idle.
                if (i_rx_byte || i_fifo_empty || !i_enable || (i_timeout_cycles == '0)) begin
                    cnt_d = '0;
                end else if (i_threshold || (cnt_q == '1)) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
                end
                if (trigger) begin
                    state_d     = S_POP;
                    timeout_set = !i_threshold;
                end
            end
            S_POP: begin
                tdata_d = i_fifo_rd_data;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                tlast_d  = i_fifo_empty;
                tvalid_d = 1'b1;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                // Continuing from HOLD relies on the level seen in CHECK; late arrivals wait for a new trigger.
                if (tvalid_q && i_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = tlast_q ? S_IDLE : S_POP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i_flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            clear_d     = 1'b1;
            timeout_set = 1'b0;
        end

        status_d = (status_q & ~i_status_clr)
                 | {timeout_set, i_overflow_error, i_frame_error, i_parity_error};
        irq_d    = |(status_q & i_irq_en);
    end

    assign o_fifo_rd_en = (state_q == S_POP) && !i_flush;
    assign o_fifo_clear = clear_q;
    assign o_tdata      = tdata_q;
    assign o_tvalid     = tvalid_q;
    assign o_tlast      = tlast_q;
    assign o_status     = status_q;
    assign o_irq        = irq_q;
    assign o_state      = state_q;

endmodule
